// File: rtl/reg_file_wb_if.sv
// Writeback/read bus between the pipeline and the integer register file.
interface reg_file_wb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  RegWrite;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] wb_result;
    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic                  rf_ready;
    logic                  wr_dropped;

    modport master (
        output RegWrite, rd_addr, wb_result, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, rf_ready, wr_dropped
    );

    modport slave (
        input  RegWrite, rd_addr, wb_result, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, rf_ready, wr_dropped
    );
endinterface

// File: rtl/reg_file_wb.sv
// Integer register file at the end of the writeback path. Two combinational
// read ports, x0 hardwired to zero, post-reset clear sequencer, optional
// same-cycle write-to-read bypass.
module reg_file_wb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32,
    parameter bit BYPASS     = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_wb_if.slave  bus
);
    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
    logic                  rf_ready_q, rf_ready_d;
    logic                  wr_dropped_q, wr_dropped_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    // Next-state: sweep zeros through the array in CLEAR, then accept writebacks.
    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        rf_ready_d   = rf_ready_q;
        wr_dropped_d = 1'b0;
        we           = 1'b0;
        waddr        = clr_idx_q;
        wdata        = '0;
        case (state_q)
            CLEAR: begin
                we           = 1'b1;
                wr_dropped_d = bus.RegWrite;
                if (clr_idx_q == LAST_IDX) begin
                    // Hold the index here rather than wrapping; it is reloaded on reset.
                    state_d    = READY;
                    rf_ready_d = 1'b1;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            READY: begin
                if (bus.RegWrite && (bus.rd_addr != '0)) begin
                    we    = 1'b1;
                    waddr = bus.rd_addr;
                    wdata = bus.wb_result;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Control state; reset restarts the clear sequence from index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            clr_idx_q    <= '0;
            rf_ready_q   <= 1'b0;
            wr_dropped_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            rf_ready_q   <= rf_ready_d;
            wr_dropped_q <= wr_dropped_d;
        end
    end

    // Storage array; deliberately left alone on the reset edge itself.
    always_ff @(posedge clk) begin
        if (!rst && we) regs_q[waddr] <= wdata;
    end

    function automatic logic [DATA_WIDTH-1:0] rd_port(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] v;
        if (a == '0)                                        v = '0;
        else if (state_q == CLEAR)                          v = '0;
        else if (BYPASS && bus.RegWrite && bus.rd_addr == a) v = bus.wb_result;
        else                                                v = regs_q[a];
        return v;
    endfunction

    // Read ports: zero while clearing so partial state never leaks out.
    always_comb begin
        bus.rs1_data = rd_port(bus.rs1_addr);
        bus.rs2_data = rd_port(bus.rs2_addr);
    end

    assign bus.rf_ready   = rf_ready_q;
    assign bus.wr_dropped = wr_dropped_q;
endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench: a BYPASS=1 and a BYPASS=0 register file driven with the
// same stimulus, each compared to a behavioural array model every cycle.
module tb_reg_file_wb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_file_wb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bb ();
    reg_file_wb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bn ();

    reg_file_wb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .BYPASS(1'b1))
        u_byp (.clk(clk), .rst(rst), .bus(bb));
    reg_file_wb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .BYPASS(1'b0))
        u_nob (.clk(clk), .rst(rst), .bus(bn));

    // Reference model: array contents plus count of clear edges still to go.
    logic [DW-1:0] mem [NR];
    int  clear_left = NR;
    bit  m_ready = 1'b0;
    bit  m_drop  = 1'b0;
    bit  m_valid = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] pre_b1, pre_b2, pre_n1, pre_n2;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_read(input int a, input bit byp, input bit we,
                                             input int rd, input logic [DW-1:0] wb);
        if (a == 0) return '0;
        if (clear_left > 0) return '0;
        if (byp && we && rd == a) return wb;
        return mem[a];
    endfunction

    // One clock: drive at negedge, check reads before the edge, update model,
    // check registered outputs after the edge.
    task automatic step(input bit r, input bit we, input int rd, input logic [DW-1:0] wb,
                        input int a1, input int a2);
        @(negedge clk);
        rst = r;
        bb.RegWrite = we; bb.rd_addr = AW'(rd); bb.wb_result = wb;
        bb.rs1_addr = AW'(a1); bb.rs2_addr = AW'(a2);
        bn.RegWrite = we; bn.rd_addr = AW'(rd); bn.wb_result = wb;
        bn.rs1_addr = AW'(a1); bn.rs2_addr = AW'(a2);
        #1;
        pre_b1 = bb.rs1_data; pre_b2 = bb.rs2_data;
        pre_n1 = bn.rs1_data; pre_n2 = bn.rs2_data;
        if (m_valid) begin
            chk("rs1_byp", pre_b1, m_read(a1, 1'b1, we, rd, wb));
            chk("rs2_byp", pre_b2, m_read(a2, 1'b1, we, rd, wb));
            chk("rs1_nob", pre_n1, m_read(a1, 1'b0, we, rd, wb));
            chk("rs2_nob", pre_n2, m_read(a2, 1'b0, we, rd, wb));
        end
        @(posedge clk);
        if (r) begin
            clear_left = NR; m_ready = 1'b0; m_drop = 1'b0; m_valid = 1'b1;
        end else if (clear_left > 0) begin
            mem[NR - clear_left] = '0;
            clear_left--;
            m_drop  = we;
            m_ready = (clear_left == 0);
        end else begin
            if (we && rd != 0) mem[rd] = wb;
            m_drop = 1'b0;
        end
        #1;
        if (m_valid) begin
            chk("ready_byp", {31'b0, bb.rf_ready},   {31'b0, m_ready});
            chk("drop_byp",  {31'b0, bb.wr_dropped}, {31'b0, m_drop});
            chk("ready_nob", {31'b0, bn.rf_ready},   {31'b0, m_ready});
            chk("drop_nob",  {31'b0, bn.wr_dropped}, {31'b0, m_drop});
        end
    endtask

    // Idle steps until rf_ready rises (bounded); returns edges taken.
    task automatic wait_ready(output int n);
        n = 0;
        while (!bb.rf_ready && n < 100) begin
            step(1'b0, 1'b0, 0, '0, n % NR, (n + 1) % NR);
            n++;
        end
    endtask

    initial begin
        int n;
        int a, rd;
        bit we, r;
        foreach (mem[i]) mem[i] = '0;
        bb.RegWrite = 1'b0; bb.rd_addr = '0; bb.wb_result = '0; bb.rs1_addr = '0; bb.rs2_addr = '0;
        bn.RegWrite = 1'b0; bn.rd_addr = '0; bn.wb_result = '0; bn.rs1_addr = '0; bn.rs2_addr = '0;

        // 1: reset 2 cycles, then ready after exactly NR edges, all regs zero
        step(1'b1, 1'b0, 0, '0, 0, 0);
        step(1'b1, 1'b1, 4, 32'h1, 0, 0);
        chk("rst_ready", {31'b0, bb.rf_ready}, 32'd0);
        chk("rst_drop",  {31'b0, bb.wr_dropped}, 32'd0);
        wait_ready(n);
        chk("t1_clear_len", 32'(n), 32'(NR));
        for (int i = 0; i < NR; i += 2) step(1'b0, 1'b0, 0, '0, i, i + 1);

        // 2: normal write then read; write to x0 discarded
        step(1'b0, 1'b1, 5, 32'hDEADBEEF, 0, 0);
        step(1'b0, 1'b0, 0, '0, 5, 0);
        chk("t2_rs1", pre_b1, 32'hDEADBEEF);
        step(1'b0, 1'b1, 0, 32'h1234, 0, 0);
        step(1'b0, 1'b0, 0, '0, 0, 0);
        chk("t2_x0", pre_b2, 32'h0);

        // 3: same-cycle bypass vs array-only
        step(1'b0, 1'b1, 7, 32'h0BAD0007, 0, 0);
        step(1'b0, 1'b1, 7, 32'hA5A5A5A5, 7, 7);
        chk("t3_byp1", pre_b1, 32'hA5A5A5A5);
        chk("t3_byp2", pre_b2, 32'hA5A5A5A5);
        chk("t3_nob1", pre_n1, 32'h0BAD0007);
        chk("t3_nob2", pre_n2, 32'h0BAD0007);

        // 4: reset in the middle of a clear restarts it
        step(1'b0, 1'b1, 3, 32'h11, 0, 0);
        step(1'b1, 1'b0, 0, '0, 0, 0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0, '0, 3, 0);
        step(1'b1, 1'b0, 0, '0, 0, 0);
        wait_ready(n);
        chk("t4_clear_len", 32'(n), 32'(NR));
        step(1'b0, 1'b0, 0, '0, 3, 0);
        chk("t4_reg3", pre_b1, 32'h0);

        // 5: write during CLEAR is dropped with a one-cycle pulse
        step(1'b1, 1'b0, 0, '0, 0, 0);
        step(1'b0, 1'b1, 9, 32'h55, 9, 0);
        chk("t5_drop", {31'b0, bb.wr_dropped}, 32'd1);
        step(1'b0, 1'b0, 0, '0, 0, 0);
        chk("t5_drop_clr", {31'b0, bb.wr_dropped}, 32'd0);
        wait_ready(n);
        step(1'b0, 1'b0, 0, '0, 9, 0);
        chk("t5_reg9", pre_b1, 32'h0);

        // 6: random traffic with occasional resets
        for (int c = 0; c < 10000; c++) begin
            r  = ($urandom_range(0, 999) == 0);
            we = $urandom_range(0, 1);
            rd = $urandom_range(0, NR - 1);
            a  = (c % 7 == 0) ? 0 : $urandom_range(0, NR - 1);
            if ($urandom_range(0, 3) == 0) a = rd;
            step(r, we, rd, $urandom, a, $urandom_range(0, NR - 1));
            if (a == 0) chk("x0_zero", pre_b1, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
